// File: rtl/skeeball_ball_tracker.sv
// rtl/skeeball_ball_tracker.sv - skeeball sensor conditioning, hit pulse generation and game sequencing
// Feeds the score block with one-hot hits, ballclk latch strobes and playstate.
module skeeball_ball_tracker #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int BALLS_PER_GAME  = 9,
    parameter int HOLDOFF_CYCLES  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] sensor,
    output logic [6:0] hit,
    output logic       ballclk,
    output logic       playstate,
    output logic [3:0] balls_left,
    output logic       game_over
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(HOLDOFF_CYCLES);
    localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HO_MAX = HW'(HOLDOFF_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, CLEAR0, CLEAR1, CLEAR2, ARMED, HOLDOFF, OVER
    } state_t;

    state_t          state, state_d;
    logic [6:0]      sensor_s1, sensor_s2, deb, deb_prev;
    logic            start_s1, start_s2, start_q;
    logic [DW-1:0]   db_cnt [7];
    logic [HW-1:0]   hcnt, hcnt_d;
    logic [3:0]      bl_d;
    logic [6:0]      hit_d, hit_req, sel;
    logic            bclk_d, start_req;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sensor_s1 <= '0;
            sensor_s2 <= '0;
            deb       <= '0;
            deb_prev  <= '0;
            start_s1  <= 1'b0;
            start_s2  <= 1'b0;
            start_q   <= 1'b0;
            for (int i = 0; i < 7; i++) db_cnt[i] <= '0;
        end else begin
            sensor_s1 <= sensor;
            sensor_s2 <= sensor_s1;
            deb_prev  <= deb;
            start_s1  <= start;
            start_s2  <= start_s1;
            start_q   <= start_s2;
            // level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
            for (int i = 0; i < 7; i++) begin
                if (sensor_s2[i] != deb[i]) begin
                    if (db_cnt[i] == DB_MAX) begin
                        deb[i]    <= sensor_s2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    assign hit_req   = deb & ~deb_prev;
    assign start_req = start_s2 & ~start_q;

    // later iterations win, so the highest-value hole takes priority
    always_comb begin
        sel = '0;
        for (int i = 0; i < 7; i++) begin
            if (hit_req[i]) sel = 7'(1) << i;
        end
    end

    always_comb begin
        state_d = state;
        hcnt_d  = hcnt;
        bl_d    = balls_left;
        hit_d   = '0;
        bclk_d  = 1'b0;
        case (state)
            IDLE:    if (start_req) state_d = CLEAR0;
            CLEAR0:  state_d = CLEAR1;
            CLEAR1:  state_d = CLEAR2;
            CLEAR2: begin
                bl_d    = 4'(BALLS_PER_GAME);
                state_d = ARMED;
            end
            ARMED: begin
                if (|hit_req) begin
                    hit_d   = sel;
                    hcnt_d  = '0;
                    state_d = HOLDOFF;
                    if (balls_left != 4'd0) bl_d = balls_left - 4'd1;
                end
            end
            HOLDOFF: begin
                // hcnt 0 and 1 schedule ballclk for T+1 and T+2
                bclk_d = (hcnt == HW'(0)) || (hcnt == HW'(1));
                if (hcnt == HO_MAX) begin
                    state_d = (balls_left == 4'd0) ? OVER : ARMED;
                end else begin
                    hcnt_d = hcnt + 1'b1;
                end
            end
            OVER: begin
                bl_d = 4'd0;
                if (start_req) state_d = CLEAR0;
            end
            default: state_d = IDLE;
        endcase
        if (state_d == CLEAR1) bclk_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            hcnt       <= '0;
            hit        <= '0;
            ballclk    <= 1'b0;
            playstate  <= 1'b0;
            balls_left <= 4'd0;
            game_over  <= 1'b0;
        end else begin
            state      <= state_d;
            hcnt       <= hcnt_d;
            hit        <= hit_d;
            ballclk    <= bclk_d;
            playstate  <= (state_d == ARMED) || (state_d == HOLDOFF);
            balls_left <= bl_d;
            game_over  <= (state_d == OVER);
        end
    end

endmodule

// File: tb/tb_skeeball_ball_tracker.sv
// tb/tb_skeeball_ball_tracker.sv - scoreboard bench for skeeball_ball_tracker
module tb_skeeball_ball_tracker;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [6:0] sensor = '0;
    logic [6:0] hit;
    logic       ballclk, playstate, game_over;
    logic [3:0] balls_left;

    int vecs = 0;
    int errs = 0;

    typedef struct {
        logic [6:0] hit;
        logic [3:0] bl;
        bit         clkchk;
    } exp_t;
    exp_t q[$];

    int acc = 0;
    int disp = 0;

    skeeball_ball_tracker dut (
        .clk(clk), .reset(reset), .start(start), .sensor(sensor),
        .hit(hit), .ballclk(ballclk), .playstate(playstate),
        .balls_left(balls_left), .game_over(game_over)
    );

    always #5 clk = ~clk;

    // score block model: digits clear while playstate=0, display latches on ballclk fall
    always @(posedge clk) begin
        if (reset || !playstate) acc <= 0;
        else if (hit != 0) acc <= acc + (hit[6] ? 100 : hit[5] ? 50 : hit[4] ? 40 :
                                         hit[3] ? 30 : hit[2] ? 20 : hit[1] ? 10 : 0);
    end
    always @(negedge ballclk) disp = acc;

    task automatic chk(input string name, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!reset && hit != 0) begin
                exp_t e;
                if (q.size() == 0) begin
                    chk("unexpected_hit", int'(hit), 0);
                end else begin
                    e = q.pop_front();
                    chk("hit_value", int'(hit), int'(e.hit));
                    chk("hit_balls_left", int'(balls_left), int'(e.bl));
                    chk("hit_ballclk_overlap", int'(ballclk), 0);
                    if (e.clkchk) begin
                        @(negedge clk); chk("ballclk_t1", int'(ballclk), 1);
                        @(negedge clk); chk("ballclk_t2", int'(ballclk), 1);
                        @(negedge clk); chk("ballclk_t3", int'(ballclk), 0);
                    end
                end
            end
        end
    end

    task automatic expect_hit(input logic [6:0] h, input logic [3:0] bl, input bit c);
        exp_t e;
        e.hit = h; e.bl = bl; e.clkchk = c;
        q.push_back(e);
    endtask

    task automatic press(input logic [6:0] pat, input int hold);
        @(posedge clk); #1 sensor = pat;
        repeat (hold) @(posedge clk);
        #1 sensor = '0;
        repeat (30) @(posedge clk);
    endtask

    task automatic wait_hit();
        bit got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (hit != 0) got = 1;
        end
        chk("hit_timeout", int'(got), 1);
    endtask

    task automatic start_game();
        int pulses = 0;
        bit up = 0;
        for (int i = 0; i < 25 && !up; i++) begin
            @(posedge clk); #1 start = (i < 3);
            @(negedge clk);
            if (ballclk) pulses++;
            if (playstate) up = 1;
        end
        start = 1'b0;
        chk("start_playstate", int'(up), 1);
        chk("clear_ballclk_width", pulses, 1);
        chk("start_balls_left", int'(balls_left), 9);
        chk("start_game_over", int'(game_over), 0);
        chk("start_score", disp, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_hit", int'(hit), 0);
        chk("rst_ballclk", int'(ballclk), 0);
        chk("rst_playstate", int'(playstate), 0);
        chk("rst_balls_left", int'(balls_left), 0);
        chk("rst_game_over", int'(game_over), 0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (3) @(posedge clk);

        start_game();

        expect_hit(7'b0010000, 4'd8, 1);
        press(7'b0010000, 10);
        chk("score_40", disp, 40);

        expect_hit(7'b0100000, 4'd7, 1);
        press(7'b0100010, 8);
        chk("score_90", disp, 90);

        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1 sensor = (i % 2 == 0) ? 7'b0000100 : 7'b0000000;
        end
        @(posedge clk); #1 sensor = '0;
        repeat (10) @(posedge clk);
        chk("glitch_no_hit_bl", int'(balls_left), 7);
        expect_hit(7'b0000100, 4'd6, 1);
        press(7'b0000100, 6);
        chk("score_110", disp, 110);

        expect_hit(7'b0001000, 4'd5, 1);
        @(posedge clk); #1 sensor = 7'b0001000;
        wait_hit();
        @(posedge clk); #1 sensor = '0;
        repeat (4) @(posedge clk);
        #1 sensor = 7'b1000000;
        repeat (8) @(posedge clk);
        #1 sensor = '0;
        repeat (30) @(posedge clk);
        chk("holdoff_discard_bl", int'(balls_left), 5);
        chk("score_140", disp, 140);

        for (int b = 4; b >= 0; b--) begin
            expect_hit(7'b0000010, 4'(b), 1);
            press(7'b0000010, 8);
        end
        @(negedge clk);
        chk("over_game_over", int'(game_over), 1);
        chk("over_playstate", int'(playstate), 0);
        chk("over_balls_left", int'(balls_left), 0);
        chk("over_score", disp, 190);
        repeat (20) @(negedge clk);
        chk("over_score_hold", disp, 190);

        start_game();
        for (int b = 8; b >= 0; b--) begin
            expect_hit(7'b0000010, 4'(b), 1);
            press(7'b0000010, 8);
        end
        @(negedge clk);
        chk("over2_game_over", int'(game_over), 1);
        chk("over2_score", disp, 90);

        start_game();
        expect_hit(7'b0000001, 4'd8, 0);
        @(posedge clk); #1 sensor = 7'b0000001;
        wait_hit();
        @(posedge clk); #1;
        chk("pre_reset_ballclk", int'(ballclk), 1);
        reset = 1'b1;
        #1;
        chk("midrst_ballclk", int'(ballclk), 0);
        chk("midrst_hit", int'(hit), 0);
        chk("midrst_playstate", int'(playstate), 0);
        chk("midrst_balls_left", int'(balls_left), 0);
        chk("midrst_game_over", int'(game_over), 0);
        sensor = '0;
        repeat (5) @(negedge clk);
        chk("queue_empty", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
